// File: rtl/mux4_scan_seq_if.sv
// Handshake/bus bundle between the scan sequencer and its environment.
// The slave side is the sequencer itself; the master side drives the
// control inputs and the downstream mux output and observes the results.
interface mux4_scan_seq_if;
    logic       i_start;
    logic       i_cont;
    logic       i_stop;
    logic [3:0] i_chMask;
    logic       i_muxOut;
    logic [1:0] o_se1;
    logic       o_busy;
    logic [3:0] o_sample;
    logic       o_frameDone;
    logic       o_err;

    modport slave (
        input  i_start,
        input  i_cont,
        input  i_stop,
        input  i_chMask,
        input  i_muxOut,
        output o_se1,
        output o_busy,
        output o_sample,
        output o_frameDone,
        output o_err
    );

    modport master (
        output i_start,
        output i_cont,
        output i_stop,
        output i_chMask,
        output i_muxOut,
        input  o_se1,
        input  o_busy,
        input  o_sample,
        input  o_frameDone,
        input  o_err
    );
endinterface

// File: rtl/mux4_scan_seq.sv
// Scan sequencer for a downstream 4:1 mux.
// Walks se1 through the enabled channels, holding each one for DWELL cycles,
// samples the mux output on the last cycle of each dwell and publishes the
// collected 4-bit snapshot with a one-cycle frame_done pulse. Frames run
// single-shot or back-to-back; a stop request ends after the current frame.
module mux4_scan_seq #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    mux4_scan_seq_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Last value of the dwell counter before the channel advances.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_se1;
    logic             r_busy;
    logic [3:0]       r_sample;
    logic [3:0]       r_shadow;
    logic             r_frameDone;
    logic             r_err;
    logic [3:0]       r_maskQ;
    logic             r_contQ;
    logic             r_stopPending;

    logic             w_lastDwell;
    logic             w_hasHigher;
    logic [1:0]       w_nextCh;
    logic [3:0]       w_shadowNext;
    logic             w_stopSeen;
    logic             w_startOk;

    // Lowest set bit of a channel mask; an empty mask yields channel 0,
    // which never matters because an empty mask never enters RUN.
    function automatic logic [1:0] lowestCh(input logic [3:0] mask);
        logic [1:0] ch;
        ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                ch = 2'(i);
            end
        end
        return ch;
    endfunction

    // Find the next enabled channel above the current one, so masked
    // channels are skipped without spending any dwell cycles on them.
    always_comb begin
        w_nextCh    = r_se1;
        w_hasHigher = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (r_maskQ[i] && (2'(i) > r_se1)) begin
                w_nextCh    = 2'(i);
                w_hasHigher = 1'b1;
            end
        end
    end

    // The mux is combinational from se1, so the bit captured at the end of
    // a dwell is merged straight into the shadow in the same cycle.
    always_comb begin
        w_shadowNext        = r_shadow;
        w_shadowNext[r_se1] = bus.i_muxOut;
    end

    assign w_lastDwell = (r_cnt == LAST_CNT);
    assign w_stopSeen  = r_stopPending | bus.i_stop;
    assign w_startOk   = (bus.i_chMask != 4'd0);

    // Sequencer state machine; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_se1         <= 2'd0;
            r_busy        <= 1'b0;
            r_sample      <= 4'd0;
            r_shadow      <= 4'd0;
            r_frameDone   <= 1'b0;
            r_err         <= 1'b0;
            r_maskQ       <= 4'd0;
            r_contQ       <= 1'b0;
            r_stopPending <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_start) begin
                        if (w_startOk) begin
                            r_state       <= RUN;
                            r_busy        <= 1'b1;
                            r_se1         <= lowestCh(bus.i_chMask);
                            r_cnt         <= '0;
                            r_maskQ       <= bus.i_chMask;
                            r_contQ       <= bus.i_cont;
                            r_stopPending <= 1'b0;
                            r_shadow      <= 4'd0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.i_stop) begin
                        r_stopPending <= 1'b1;
                    end
                    if (!w_lastDwell) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                        if (w_hasHigher) begin
                            r_se1    <= w_nextCh;
                            r_shadow <= w_shadowNext;
                        end else begin
                            r_sample    <= w_shadowNext;
                            r_frameDone <= 1'b1;
                            r_shadow    <= 4'd0;
                            if (r_contQ && !w_stopSeen) begin
                                r_se1 <= lowestCh(r_maskQ);
                            end else begin
                                r_state       <= IDLE;
                                r_busy        <= 1'b0;
                                r_se1         <= 2'd0;
                                r_stopPending <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_se1   <= 2'd0;
                end
            endcase
        end
    end

    assign bus.o_se1       = r_se1;
    assign bus.o_busy      = r_busy;
    assign bus.o_sample    = r_sample;
    assign bus.o_frameDone = r_frameDone;
    assign bus.o_err       = r_err;

endmodule

// File: tb/tb_mux4_scan_seq.sv
// Testbench for mux4_scan_seq: directed scenarios followed by a long random
// run, every cycle compared against a frame-level reference model that works
// from the list of enabled channels and the elapsed cycle count in a frame.
module tb_mux4_scan_seq;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] chanVal;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model state
    bit         mBusy;
    int         mList[$];
    int         mElapsed;
    bit         mCont;
    bit         mStopPend;
    logic [3:0] mSample;
    logic [3:0] mAcc;
    bit         mFrameDone;
    bit         mErr;

    mux4_scan_seq_if bus();

    // Downstream 4:1 mux driven by the sequencer's select.
    assign bus.i_muxOut = chanVal[bus.o_se1];

    mux4_scan_seq #(
        .DWELL (DWELL),
        .CNT_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] expSe1();
        if (mBusy) begin
            return 2'(mList[mElapsed / DWELL]);
        end
        return 2'd0;
    endfunction

    // One clock edge of the reference model, using the pre-edge inputs.
    task automatic modelStep(input bit r, input bit s, input bit c, input bit st,
                             input logic [3:0] m);
        int ch;
        if (r) begin
            mBusy = 0; mList.delete(); mElapsed = 0; mCont = 0; mStopPend = 0;
            mSample = 4'd0; mAcc = 4'd0; mFrameDone = 0; mErr = 0;
            return;
        end
        mFrameDone = 0;
        mErr       = 0;
        if (!mBusy) begin
            if (s) begin
                if (m == 4'd0) begin
                    mErr = 1;
                end else begin
                    mList.delete();
                    for (int i = 0; i < 4; i++) begin
                        if (m[i]) mList.push_back(i);
                    end
                    mBusy = 1; mElapsed = 0; mCont = c; mStopPend = 0; mAcc = 4'd0;
                end
            end
        end else begin
            if (st) mStopPend = 1;
            ch = mList[mElapsed / DWELL];
            if ((mElapsed % DWELL) == DWELL - 1) mAcc[ch] = chanVal[ch];
            if (mElapsed == mList.size() * DWELL - 1) begin
                mSample    = mAcc;
                mFrameDone = 1;
                mElapsed   = 0;
                mAcc       = 4'd0;
                if (!(mCont && !mStopPend)) begin
                    mBusy     = 0;
                    mStopPend = 0;
                end
            end else begin
                mElapsed++;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then compare.
    task automatic applyStimulus(input bit r, input bit s, input bit c, input bit st,
                                 input logic [3:0] m, input logic [3:0] cv);
        @(negedge clk);
        rst          = r;
        bus.i_start  = s;
        bus.i_cont   = c;
        bus.i_stop   = st;
        bus.i_chMask = m;
        chanVal      = cv;
        @(posedge clk);
        modelStep(r, s, c, st, m);
        #1;
        checkOutput("se1", 32'(bus.o_se1), 32'(expSe1()));
        checkOutput("busy", 32'(bus.o_busy), 32'(mBusy));
        checkOutput("sample", 32'(bus.o_sample), 32'(mSample));
        checkOutput("frame_done", 32'(bus.o_frameDone), 32'(mFrameDone));
        checkOutput("err", 32'(bus.o_err), 32'(mErr));
    endtask

    initial begin
        // Reset with random inputs on the other pins
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1'($urandom), 1'($urandom), 1'($urandom),
                          4'($urandom), 4'($urandom));
        end
        checkOutput("t1_se1", 32'(bus.o_se1), 0);
        checkOutput("t1_sample", 32'(bus.o_sample), 0);
        applyStimulus(0, 0, 0, 0, 4'd0, 4'd0);

        // Full mask, channel values in0..in3 = 1,0,1,1
        applyStimulus(0, 1, 0, 0, 4'b1111, 4'b1101);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(0, 0, 0, 0, 4'b0000, 4'b1101);
            if (k <= 15) checkOutput("t2_se1_walk", 32'(bus.o_se1), 32'((k) / 4));
        end
        checkOutput("t2_frame_done", 32'(bus.o_frameDone), 1);
        checkOutput("t2_sample", 32'(bus.o_sample), 32'(4'b1101));
        checkOutput("t2_busy", 32'(bus.o_busy), 0);
        applyStimulus(0, 0, 0, 0, 4'd0, 4'd0);

        // Sparse mask skips disabled channels
        applyStimulus(0, 1, 0, 0, 4'b1010, 4'b1111);
        checkOutput("t3_se1_first", 32'(bus.o_se1), 1);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 0, 0, 0, 4'b0000, 4'b1111);
            if (k == 4) checkOutput("t3_se1_second", 32'(bus.o_se1), 3);
        end
        checkOutput("t3_frame_done", 32'(bus.o_frameDone), 1);
        checkOutput("t3_sample", 32'(bus.o_sample), 32'(4'b1010));

        // Empty mask flags an error and leaves the sample alone
        applyStimulus(0, 1, 0, 0, 4'b0000, 4'b0000);
        checkOutput("t4_err", 32'(bus.o_err), 1);
        checkOutput("t4_busy", 32'(bus.o_busy), 0);
        applyStimulus(0, 0, 0, 0, 4'b0000, 4'b0000);
        checkOutput("t4_err_clear", 32'(bus.o_err), 0);
        checkOutput("t4_sample_held", 32'(bus.o_sample), 32'(4'b1010));

        // Continuous single-channel frames, stop during the third frame
        applyStimulus(0, 1, 1, 0, 4'b0001, 4'($urandom));
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(0, 0, 0, (k == 10), 4'b0000, 4'($urandom));
            if (k == 4 || k == 8) begin
                checkOutput("t5_frame_done_mid", 32'(bus.o_frameDone), 1);
                checkOutput("t5_busy_mid", 32'(bus.o_busy), 1);
            end
        end
        checkOutput("t5_frame_done_last", 32'(bus.o_frameDone), 1);
        checkOutput("t5_busy_last", 32'(bus.o_busy), 0);

        // Reset mid-frame abandons it; start while busy is ignored
        applyStimulus(0, 1, 0, 0, 4'b1111, 4'($urandom));
        for (int k = 1; k <= 5; k++) applyStimulus(0, 1, 0, 0, 4'b1111, 4'($urandom));
        applyStimulus(1, 0, 0, 0, 4'b1111, 4'($urandom));
        checkOutput("t6_busy_rst", 32'(bus.o_busy), 0);
        checkOutput("t6_frame_done_rst", 32'(bus.o_frameDone), 0);
        checkOutput("t6_sample_rst", 32'(bus.o_sample), 0);
        applyStimulus(0, 1, 0, 0, 4'b1111, 4'($urandom));
        for (int k = 1; k <= 16; k++) applyStimulus(0, 1, 1, 0, 4'b0110, 4'($urandom));
        checkOutput("t6_frame_done_timing", 32'(bus.o_frameDone), 1);

        // Long random run against the model
        for (int n = 0; n < 4000; n++) begin
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 5) == 0),
                          1'($urandom),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom),
                          4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
